// File: rtl/lalu_pkg.sv
// Shared constants, types and helpers for the LALU instruction fetch stage.
package lalu_pkg;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_DISCARD = 2'b10
    } fetch_state_t;

    // Sequential word address; wraps naturally at the top of the address space.
    function automatic logic [ADDR_W-1:0] next_word_pc(input logic [ADDR_W-1:0] pc);
        return pc + {{(ADDR_W-3){1'b0}}, 3'b100};
    endfunction
endpackage

// File: rtl/lalu_fifo.sv
// Prefetch FIFO of {data, pc} entries; flush wins over push and pop.
module lalu_fifo
    import lalu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head_data,
    output logic               full,
    output logic               empty,
    output logic [PTR_W:0]     count
);
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (count == {(PTR_W+1){1'b0}});
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign head_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A push into a full FIFO is accepted only when a pop frees the head slot.
    always_comb begin
        do_pop   = pop & ~empty & ~flush;
        do_push  = push & ~flush & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = {(PTR_W+1){1'b0}};
            rd_ptr_d = {(PTR_W+1){1'b0}};
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {(PTR_W+1){1'b0}};
            rd_ptr_q <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/lalu_fetch.sv
// LALU fetch stage: single-outstanding imem requests feeding a prefetch FIFO,
// with redirect flushing the FIFO and discarding any in-flight response.
module lalu_fetch #(
    parameter int ADDR_W = lalu_pkg::ADDR_W,
    parameter int DATA_W = lalu_pkg::DATA_W,
    parameter int DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = lalu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);
    import lalu_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               req_q, req_d;
    logic               push, pop, flush, has_space;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count, count_next;
    logic [ENTRY_W-1:0] head_bits;
    fetch_entry_t       push_entry, head_entry;

    lalu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_entry = fetch_entry_t'(head_bits);
    assign inst_valid = ~fifo_empty;
    assign inst_data  = head_entry.data;
    assign inst_pc    = head_entry.pc;
    assign imem_req   = req_q;
    assign imem_addr  = addr_q;

    // Next-state logic; a new request is only issued when next cycle's
    // occupancy leaves room for its response.
    always_comb begin
        flush           = redirect_valid;
        pop             = ~fifo_empty & inst_ready & ~redirect_valid;
        push            = (state_q == ST_REQ) & imem_ack & ~redirect_valid & (~fifo_full | pop);
        push_entry.data = imem_rdata;
        push_entry.pc   = addr_q;
        if (flush) begin
            count_next = {CNT_W{1'b0}};
        end else begin
            count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
        has_space  = (count_next < CNT_W'(DEPTH));
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = ST_REQ;
                end else if (has_space) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = imem_ack ? ST_REQ : ST_DISCARD;
                end else if (imem_ack) begin
                    fetch_pc_d = next_word_pc(fetch_pc_q);
                    state_d    = has_space ? ST_REQ : ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                state_d = imem_ack ? ST_REQ : ST_DISCARD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d  = (state_d != ST_IDLE);
        addr_d = (state_d == ST_REQ) ? fetch_pc_d : addr_q;
    end

    // FSM, fetch PC and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end
endmodule

// File: tb/tb_lalu_fetch.sv
// Bench for lalu_fetch: queue-based reference model, directed scenarios and random traffic.
module tb_lalu_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    always #5 clk = ~clk;

    lalu_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t        mq[$];
    bit          m_out = 1'b0;
    bit          m_disc = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_addr = 32'h0;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    bit          addr_data = 1'b1;
    int          ack_pct = 100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a request is in flight or not; with none in flight a new one
    // starts whenever the buffer (after this cycle's pops/pushes) has room.
    task automatic model_step();
        bit still_out;
        if (rst) begin
            mq.delete();
            m_out  = 1'b0;
            m_disc = 1'b0;
            m_pc   = 32'h0;
            m_addr = 32'h0;
        end else begin
            if (redirect_valid) begin
                mq.delete();
            end else begin
                if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
                if (m_out && imem_ack && !m_disc) begin
                    mq.push_back('{d: imem_rdata, p: m_addr});
                    m_pc = m_addr + 32'd4;
                end
            end
            still_out = m_out && !imem_ack;
            if (redirect_valid) begin
                m_pc = redirect_pc;
                if (still_out) m_disc = 1'b1;
            end
            if (!still_out) begin
                m_disc = 1'b0;
                if (mq.size() < 4) begin
                    m_out  = 1'b1;
                    m_addr = m_pc;
                end else begin
                    m_out = 1'b0;
                end
            end
        end
    endtask

    // ack_sel: 0 none, 1 ack if requesting, 2 random (spurious when idle), 3 forced.
    task automatic step(input bit r, input int ack_sel, input bit rdy, input bit redir,
                        input logic [31:0] rpc);
        @(negedge clk);
        #1;
        rst            = r;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        case (ack_sel)
            0: imem_ack = 1'b0;
            1: imem_ack = m_out;
            2: imem_ack = m_out ? ($urandom_range(0, 99) < ack_pct) : ($urandom_range(0, 7) == 0);
            default: imem_ack = 1'b1;
        endcase
        imem_rdata = addr_data ? m_addr : $urandom;
        @(posedge clk);
        model_step();
        #1;
        chk_en = 1'b1;
    endtask

    // Cycle-by-cycle comparison against the reference model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", {31'd0, imem_req}, {31'd0, m_out});
            if (m_out) chk("addr", imem_addr, m_addr);
            chk("valid", {31'd0, inst_valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("data", inst_data, mq[0].d);
                chk("pc", inst_pc, mq[0].p);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rpc;
        bit          r, rdy, redir;
        int          sel;

        // Reset values
        repeat (3) step(1'b1, 0, 1'b0, 1'b0, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);

        // Zero-wait streaming, addr-as-data
        step(1'b0, 1, 1'b1, 1'b0, 32'h0);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        step(1'b0, 1, 1'b1, 1'b0, 32'h0);
        chk("first_valid", {31'd0, inst_valid}, 32'd1);
        chk("first_pc", inst_pc, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1, 1'b1, 1'b0, 32'h0);
            chk("stream_valid", {31'd0, inst_valid}, 32'd1);
            chk("stream_pc", inst_pc, 32'(4 * k));
            chk("stream_data", inst_data, 32'(4 * k));
        end

        // Back-pressure: restart at 0 and hold ready low
        step(1'b0, 1, 1'b0, 1'b1, 32'h0);
        repeat (10) step(1'b0, 1, 1'b0, 1'b0, 32'h0);
        chk("full_model", 32'(mq.size()), 32'd4);
        chk("full_req", {31'd0, imem_req}, 32'd0);
        chk("full_head", inst_pc, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1, 1'b1, 1'b0, 32'h0);
            chk("drain_pc", inst_pc, 32'(4 * k));
        end

        // Latency-3 memory, redirect to 0x100 while fetching 0x8
        step(1'b1, 0, 1'b1, 1'b0, 32'h0);
        for (int i = 1; i <= 14; i++) begin
            step(1'b0, (i == 4 || i == 7 || i == 11 || i == 14) ? 1 : 0, 1'b1, (i == 9),
                 32'h100);
            if (i == 9) begin
                chk("disc_addr", imem_addr, 32'h8);
                chk("disc_valid", {31'd0, inst_valid}, 32'd0);
            end
            if (i == 11) begin
                chk("redir_req", {31'd0, imem_req}, 32'd1);
                chk("redir_addr", imem_addr, 32'h100);
                chk("redir_valid", {31'd0, inst_valid}, 32'd0);
            end
            if (i == 14) chk("redir_pc", inst_pc, 32'h100);
        end

        // Redirect coincident with ack and pop, two entries buffered
        step(1'b1, 0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1, 1'b0, 1'b0, 32'h0);
        chk("two_model", 32'(mq.size()), 32'd2);
        step(1'b0, 1, 1'b1, 1'b1, 32'h40);
        chk("flush_valid", {31'd0, inst_valid}, 32'd0);
        chk("flush_addr", imem_addr, 32'h40);
        step(1'b0, 1, 1'b1, 1'b0, 32'h0);
        chk("flush_pc", inst_pc, 32'h40);

        // Address wrap
        step(1'b0, 1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        step(1'b0, 1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
        step(1'b0, 1, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        step(1'b0, 1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc", inst_pc, 32'h0);

        // Reset with a request outstanding, ack during and right after reset
        step(1'b0, 0, 1'b1, 1'b0, 32'h0);
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        step(1'b1, 0, 1'b1, 1'b0, 32'h0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        step(1'b1, 3, 1'b1, 1'b0, 32'h0);
        chk("rst_ack_valid", {31'd0, inst_valid}, 32'd0);
        step(1'b0, 3, 1'b1, 1'b0, 32'h0);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_valid", {31'd0, inst_valid}, 32'd0);
        step(1'b0, 1, 1'b1, 1'b0, 32'h0);
        chk("post_rst_pc", inst_pc, 32'h0);

        // Random traffic
        addr_data = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                sel = $urandom_range(0, 2);
                ack_pct = (sel == 0) ? 100 : ((sel == 1) ? 50 : 25);
            end
            r     = ($urandom_range(0, 499) == 0);
            redir = ($urandom_range(0, 29) == 0);
            rdy   = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 3) == 0) begin
                rpc = 32'hFFFF_FFF0 | (32'($urandom) & 32'h0000_000C);
            end else begin
                rpc = 32'($urandom_range(0, 1023)) << 2;
            end
            step(r, 2, rdy, redir, rpc);
        end

        step(1'b0, 0, 1'b1, 1'b0, 32'h0);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
